// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, optional even parity
// (SYNC_FRAME_TX_PARITY_EN), then zero gap bits. Feeds the 1011 sync detector.
module sync_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
  parameter int                GAP_LEN  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              x,
  output logic              busy,
  output logic              done
);

`ifdef SYNC_FRAME_TX_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int TOT_W = SYNC_W + DATA_W + PAR_W;
  localparam int MAXL1 = (SYNC_W > DATA_W + 1) ? SYNC_W : DATA_W + 1;
  localparam int MAXL  = (MAXL1 > GAP_LEN) ? MAXL1 : GAP_LEN;
  localparam int CW    = $clog2(MAXL + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef SYNC_FRAME_TX_PARITY_EN
    PAR,
`endif
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TOT_W-1:0]  fr_q, fr_d;
  logic              x_q, x_d;
  logic [TOT_W-1:0]  frame_w;

`ifdef SYNC_FRAME_TX_PARITY_EN
  assign frame_w = {SYNC_PAT, data_in, ^data_in};
`else
  assign frame_w = {SYNC_PAT, data_in};
`endif

  // x is registered, so each state computes the bit for the cycle it leads into;
  // the frame shift register always holds the next bit to send at its MSB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fr_d    = fr_q;
    x_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load) begin
          state_d = SYNC;
          cnt_d   = CW'(SYNC_W - 1);
          x_d     = frame_w[TOT_W-1];
          fr_d    = frame_w << 1;
        end
      end
      SYNC: begin
        x_d  = fr_q[TOT_W-1];
        fr_d = fr_q << 1;
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CW'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
          state_d = PAR;
          cnt_d   = '0;
          x_d     = fr_q[TOT_W-1];
          fr_d    = fr_q << 1;
`else
          state_d = GAP;
          cnt_d   = CW'(GAP_LEN - 1);
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
          x_d   = fr_q[TOT_W-1];
          fr_d  = fr_q << 1;
        end
      end
`ifdef SYNC_FRAME_TX_PARITY_EN
      PAR: begin
        state_d = GAP;
        cnt_d   = CW'(GAP_LEN - 1);
      end
`endif
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fr_q    <= '0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fr_q    <= fr_d;
      x_q     <= x_d;
    end
  end

  assign x     = x_q;
  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == GAP) && (cnt_q == CW'(GAP_LEN - 1));

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx (DATA_W=8, SYNC_W=4, SYNC_PAT=1011, GAP_LEN=2).
module tb_sync_frame_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, x, busy, done;
  int         tests = 0;
  int         fails = 0;
  int         det_cnt, det_pos;
  logic [3:0] hist;

`ifdef SYNC_FRAME_TX_PARITY_EN
  localparam int F = 15;
  localparam logic [F-1:0] EXP_A5 = 15'b1011_10100101_0_00;
  localparam logic [F-1:0] EXP_01 = 15'b1011_00000001_1_00;
  localparam logic [F-1:0] EXP_3C = 15'b1011_00111100_0_00;
  localparam logic [F-1:0] EXP_C3 = 15'b1011_11000011_0_00;
  localparam logic [F-1:0] EXP_5A = 15'b1011_01011010_0_00;
`else
  localparam int F = 14;
  localparam logic [F-1:0] EXP_A5 = 14'b1011_10100101_00;
  localparam logic [F-1:0] EXP_01 = 14'b1011_00000001_00;
  localparam logic [F-1:0] EXP_3C = 14'b1011_00111100_00;
  localparam logic [F-1:0] EXP_C3 = 14'b1011_11000011_00;
  localparam logic [F-1:0] EXP_5A = 14'b1011_01011010_00;
`endif

  sync_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .GAP_LEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .ready(ready), .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; walks the whole frame and the return to idle.
  task automatic check_frame(input string tag, input logic [F-1:0] exp, input bit junk);
    det_cnt = 0;
    det_pos = 0;
    hist    = 4'b0000;
    for (int k = 1; k <= F; k++) begin
      chk({tag, ".x"},     32'(x),     32'(exp[F-k]));
      chk({tag, ".ready"}, 32'(ready), 32'd0);
      chk({tag, ".busy"},  32'(busy),  32'd1);
      chk({tag, ".done"},  32'(done),  32'(k == F - 1));
      hist = {hist[2:0], x};
      if (hist == 4'b1011) begin
        det_cnt++;
        det_pos = k;
      end
      if (junk) data_in = 8'($urandom);
      step;
    end
    chk({tag, ".idle_ready"}, 32'(ready), 32'd1);
    chk({tag, ".idle_busy"},  32'(busy),  32'd0);
    chk({tag, ".idle_x"},     32'(x),     32'd0);
    chk({tag, ".idle_done"},  32'(done),  32'd0);
  endtask

  initial begin
    // 1: reset
    rst_n = 1'b0;
    step;
    chk("rst.x", 32'(x), 32'd0);
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("idle.ready", 32'(ready), 32'd1);

    // 2/3: single frames, A5 then 01 (parity bit differs when enabled)
    load = 1'b1; data_in = 8'hA5;
    step;
    load = 1'b0; data_in = 8'h00;
    check_frame("a5", EXP_A5, 1'b0);
    load = 1'b1; data_in = 8'h01;
    step;
    load = 1'b0;
    check_frame("01", EXP_01, 1'b1);

    // 4: load held high, data changing every cycle
    load = 1'b1; data_in = 8'h3C;
    step;
    check_frame("hold1", EXP_3C, 1'b1);
    data_in = 8'hC3;
    step;
    check_frame("hold2", EXP_C3, 1'b1);
    load = 1'b0; data_in = 8'h00;
    step;
    chk("hold_end.ready", 32'(ready), 32'd1);

    // 5: reset during the third payload bit
    load = 1'b1; data_in = 8'hA5;
    step;
    load = 1'b0;
    for (int i = 0; i < 6; i++) step;
    chk("mid.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("abort.x", 32'(x), 32'd0);
    chk("abort.ready", 32'(ready), 32'd1);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("abort.no_done", 32'(done), 32'd0);
    end
    load = 1'b1; data_in = 8'h5A;
    step;
    load = 1'b0;
    check_frame("clean", EXP_5A, 1'b0);

    // 6: loopback into a 1011 detector model
    load = 1'b1; data_in = 8'hA5;
    step;
    load = 1'b0;
    check_frame("loop", EXP_A5, 1'b0);
    chk("loop.y_count", 32'(det_cnt), 32'd1);
    chk("loop.y_pos", 32'(det_pos), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
